// File: rtl/music_pkg.sv
// Shared types and constants for the music playback sequencer.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } play_state_t;

  localparam logic [1:0] SONG_0 = 2'd0;
  localparam logic [1:0] SONG_1 = 2'd1;
  localparam logic [1:0] SONG_2 = 2'd2;
  localparam logic [1:0] SONG_3 = 2'd3;

  // 8 Hz beat at a 50 MHz clk
  localparam int unsigned BEAT_DIV_DEFAULT = 6250000;

endpackage

// File: rtl/beat_timer.sv
// Beat timebase: counts 0..DIV-1 while enabled, holds otherwise, clear has priority.
module beat_timer #(
  parameter int unsigned DIV = 4,
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/music_play_ctrl.sv
// Playback sequencer: song select, beat-stepped index, pause and return-to-menu.
// Define MUSIC_LOOP_EN to wrap the step index at end of song instead of stopping in DONE.
module music_play_ctrl
  import music_pkg::*;
#(
  parameter int unsigned BEAT_DIV = BEAT_DIV_DEFAULT,
  parameter int unsigned STEP_W   = 8,
  parameter int unsigned SONG_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SONG_W-1:0] song_sel,
  input  logic [STEP_W-1:0] song_len,
  input  logic              pause,
  input  logic              over,
  output logic [STEP_W-1:0] step,
  output logic [SONG_W-1:0] song_id,
  output logic              beat_tick,
  output logic              mute,
  output logic              playing,
  output logic              get_pause,
  output logic              get_return,
  output logic              done
);

  play_state_t       state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] len_q, len_d;
  logic [STEP_W-1:0] last_step;
  logic [SONG_W-1:0] song_id_q, song_id_d;
  logic              beat_tick_q, beat_tick_d;
  logic              get_return_q, get_return_d;
  logic              over_armed_q, over_armed_d;
  logic              over_act, start_ok, tmr_en, tmr_clr, tmr_tc;

  assign over_act  = over && (state_q != IDLE);
  assign start_ok  = start && !over && (song_len != '0) &&
                     ((state_q == IDLE) || (state_q == DONE));
  assign tmr_en    = (state_q == PLAY) && !over && !pause;
  assign tmr_clr   = over_act || (state_q == IDLE) || (state_q == DONE);
  assign last_step = len_q - STEP_W'(1);

  beat_timer #(.DIV(BEAT_DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tmr_en),
    .clr   (tmr_clr),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    len_d        = len_q;
    song_id_d    = song_id_q;
    beat_tick_d  = 1'b0;
    get_return_d = 1'b0;
    // one return pulse per over assertion; re-armed only once over is seen low
    if (!over) begin
      over_armed_d = 1'b1;
    end else if (over_act) begin
      over_armed_d = 1'b0;
    end else begin
      over_armed_d = over_armed_q;
    end

    if (over_act) begin
      state_d      = IDLE;
      step_d       = '0;
      song_id_d    = '0;
      get_return_d = over_armed_q;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_d   = PLAY;
            step_d    = '0;
            len_d     = song_len;
            song_id_d = song_sel;
          end
        end
        PLAY: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tmr_tc) begin
            beat_tick_d = 1'b1;
            if (step_q >= last_step) begin
`ifdef MUSIC_LOOP_EN
              step_d = '0;
`else
              state_d = DONE;
`endif
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_d = PLAY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      len_q        <= '0;
      song_id_q    <= '0;
      beat_tick_q  <= 1'b0;
      get_return_q <= 1'b0;
      over_armed_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      len_q        <= len_d;
      song_id_q    <= song_id_d;
      beat_tick_q  <= beat_tick_d;
      get_return_q <= get_return_d;
      over_armed_q <= over_armed_d;
    end
  end

  assign step       = step_q;
  assign song_id    = song_id_q;
  assign beat_tick  = beat_tick_q;
  assign get_return = get_return_q;
  assign mute       = (state_q != PLAY);
  assign playing    = (state_q == PLAY);
  assign get_pause  = (state_q == PAUSE);
  assign done       = (state_q == DONE);

endmodule

// File: doc/music_play_ctrl.md
Name: music_play_ctrl

Overview:
- Playback sequencer for the auto-play subsystem. Owns the beat timebase and step index that drive the song note ROMs and the note-to-tone generator.
- Selects one of up to four songs and runs it from step 0 to its last step.
- Handles pause/resume and the return-to-menu request.
- Sits between the mode/menu logic and the song ROM + tone datapath. Replaces the per-song free-running counters with one shared, resettable controller.

Parameters:
- BEAT_DIV, 6250000, clk cycles per beat step (8 Hz at 50 MHz); must be >= 2
- STEP_W, 8, width of step index and song length
- SONG_W, 2, width of song select

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin the song on song_sel
- song_sel  in  SONG_W  requested song, sampled with start
- song_len  in  STEP_W  step count of the selected song (from ROM side), sampled with start
- pause  in  1  level; high holds playback
- over  in  1  level; return-to-menu request
- step  out  STEP_W  current step index to song ROM
- song_id  out  SONG_W  latched song to song ROM mux
- beat_tick  out  1  one-cycle pulse on each step advance
- mute  out  1  high when the tone datapath must be silent
- playing  out  1  high in PLAY
- get_pause  out  1  high in PAUSE
- get_return  out  1  one-cycle pulse on accepted over
- done  out  1  high in DONE

Behaviour:
- Reset values: step=0, song_id=0, beat_tick=0, mute=1, playing=0, get_pause=0, get_return=0, done=0. Beat counter=0, state IDLE.
- States: IDLE, PLAY, PAUSE, DONE (shared enum).
- IDLE/DONE, start=1, song_len!=0:
  - latch song_sel into song_id and song_len into len_q
  - step=0, beat counter=0
  - go to PLAY next cycle
- IDLE/DONE, start=1, song_len=0: request ignored; state unchanged.
- Start while in PLAY or PAUSE: ignored; song_id and len_q are not re-latched.
- Beat counter:
  - counts 0..BEAT_DIV-1 only in PLAY; holds in PAUSE; cleared in IDLE/DONE
  - beat_tick is registered and asserts the cycle after the counter equals BEAT_DIV-1
  - step increments in that same cycle
- Step end: if the tick would advance step past len_q-1, step stays at len_q-1 and state goes to DONE. No wrap; step never exceeds len_q-1.
- PLAY and pause=1: PAUSE next cycle. Counter and step frozen, get_pause=1, mute=1.
- PAUSE and pause=0: PLAY next cycle; the counter resumes from its held value.
- over=1 in any state other than IDLE:
  - go to IDLE next cycle
  - get_return pulses for exactly one cycle
  - step, beat counter and song_id clear to 0
- over held high: get_return is not re-pulsed until over has been observed low.
- over=1 while in IDLE: no pulse.
- Priority in a single cycle: over > pause > beat advance > start.
- mute = !(state==PLAY). playing, get_pause and done decode state directly.
- All outputs are registered; no combinational path from input to output.
- Reset asserted mid-song: immediate return to reset values; no get_return pulse.

Optional Feature:
- Macro: MUSIC_LOOP_EN
- Defined: at the end of a song, step wraps to 0 and the controller stays in PLAY. beat_tick is still pulsed. DONE is unreachable; done stays 0.
- Undefined: end-of-song behaviour is as described above (go to DONE).

Decomposition:
- Package music_pkg holds:
  - play_state_t enum (IDLE, PLAY, PAUSE, DONE)
  - song id constants SONG_0..SONG_3
  - default BEAT_DIV
- One sub-module, beat_timer: counter with enable, clear and terminal-count pulse. The FSM stays in music_play_ctrl.

Test Plan (BEAT_DIV=4):
- Basic play: start with song_sel=2, song_len=3 → song_id=2, playing=1 next cycle. beat_tick every 4 cycles; step 0→1→2. On the third tick, done=1 and step stays 2. Never pulses past 2.
- Pause: pause=1 at counter value 2 → get_pause=1, mute=1; step and counter frozen for 10 cycles. Release pause → next tick arrives 2 cycles after resume.
- Return: assert over during PAUSE and hold it 5 cycles → exactly one get_return pulse; IDLE; step=0, song_id=0.
- Boundary cases:
  - start with song_len=0 → stays IDLE, mute=1
  - start asserted mid-PLAY → song_id unchanged
- Priority and reset:
  - over and pause together in PLAY → IDLE, not PAUSE
  - rst_n low mid-song → all outputs at reset values asynchronously
- MUSIC_LOOP_EN, song_len=2 → step sequence 0,1,0,1…; done stays 0.
